// File: rtl/systolic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | systolic_pkg: shared constants, FSM encoding and helpers for the     |
// | systolic operand feeder.                          Revision: 1.0      |
// +----------------------------------------------------------------------+
package systolic_pkg;

    localparam int N_DEF  = 2;
    localparam int DW_DEF = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic int feed_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_skew_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | systolic_skew_mux: picks the diagonally skewed operand for one edge  |
// | lane at feed step t, or zero outside its window.  Revision: 1.0      |
// +----------------------------------------------------------------------+
module systolic_skew_mux
    import systolic_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int DW   = DW_DEF,
    parameter int TW   = 3,
    parameter int IDX  = 0,
    parameter int IS_B = 0
) (
    input  logic [TW-1:0]     t,
    input  logic [N*N*DW-1:0] mat,
    output logic [DW-1:0]     q
);

    logic [DW-1:0] w_tap [N];

    // Tap k is the operand lane IDX consumes at step IDX+k: A[IDX][k] or B[k][IDX].
    generate
        for (genvar k = 0; k < N; k++) begin : g_tap
            localparam int EL = (IS_B != 0) ? (k * N + IDX) : (IDX * N + k);
            assign w_tap[k] = (t == TW'(IDX + k)) ? mat[EL*DW +: DW] : '0;
        end
    endgenerate

    always_comb begin
        q = '0;
        for (int k = 0; k < N; k++) begin
            q = q | w_tap[k];
        end
    end

endmodule
`default_nettype wire

// File: rtl/systolic_operand_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | systolic_operand_feeder: buffers A and B, then streams skewed rows   |
// | and columns into the systolic array.              Revision: 1.0      |
// +----------------------------------------------------------------------+
module systolic_operand_feeder
    import systolic_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DW    = DW_DEF,
    parameter int DRAIN = 4,
    parameter int IW    = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [IW-1:0]   wr_row,
    input  logic [IW-1:0]   wr_col,
    input  logic [DW-1:0]   wr_data,
    output logic            wr_err,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            acc_clear,
    output logic            feed_valid,
    output logic [N*DW-1:0] a_edge,
    output logic [N*DW-1:0] b_edge
);

    localparam int FEED_LEN = feed_len(N);
    localparam int CNT_MAX  = (FEED_LEN > DRAIN) ? FEED_LEN : DRAIN;
    localparam int CW       = $clog2(CNT_MAX + 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N*N*DW-1:0] a_q, a_d, b_q, b_d;
    logic              busy_q, busy_d, done_q, done_d, acc_clear_q, acc_clear_d;
    logic              feed_valid_q, feed_valid_d, wr_err_q, wr_err_d;
    logic [N*DW-1:0]   a_edge_q, a_edge_d, b_edge_q, b_edge_d;

    logic                  w_wr_ok;
    logic [N-1:0][DW-1:0]  w_a_tap, w_b_tap;

    assign w_wr_ok = wr_en && (state_q == S_IDLE)
                     && (32'(wr_row) < N) && (32'(wr_col) < N);

    generate
        for (genvar e = 0; e < N * N; e++) begin : g_elem
            logic w_hit;
            assign w_hit = w_wr_ok && (32'(wr_row) == e / N) && (32'(wr_col) == e % N);
            assign a_d[e*DW +: DW] = (w_hit && !wr_sel) ? wr_data : a_q[e*DW +: DW];
            assign b_d[e*DW +: DW] = (w_hit &&  wr_sel) ? wr_data : b_q[e*DW +: DW];
        end

        // Edges are registered, so the muxes look at the step about to be entered.
        for (genvar i = 0; i < N; i++) begin : g_lane
            systolic_skew_mux #(.N(N), .DW(DW), .TW(CW), .IDX(i), .IS_B(0)) u_a_mux (
                .t   (cnt_d),
                .mat (a_q),
                .q   (w_a_tap[i])
            );
            systolic_skew_mux #(.N(N), .DW(DW), .TW(CW), .IDX(i), .IS_B(1)) u_b_mux (
                .t   (cnt_d),
                .mat (b_q),
                .q   (w_b_tap[i])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                if (cnt_q == CW'(FEED_LEN - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CW'(DRAIN - 1)) state_d = S_DONE;
                else                         cnt_d   = cnt_q + 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        acc_clear_d  = (state_d == S_CLEAR);
        feed_valid_d = (state_d == S_FEED);
        wr_err_d     = wr_en && !w_wr_ok;
        a_edge_d     = (state_d == S_FEED) ? w_a_tap : '0;
        b_edge_d     = (state_d == S_FEED) ? w_b_tap : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            acc_clear_q  <= 1'b0;
            feed_valid_q <= 1'b0;
            wr_err_q     <= 1'b0;
            a_edge_q     <= '0;
            b_edge_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            acc_clear_q  <= acc_clear_d;
            feed_valid_q <= feed_valid_d;
            wr_err_q     <= wr_err_d;
            a_edge_q     <= a_edge_d;
            b_edge_q     <= b_edge_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign acc_clear  = acc_clear_q;
    assign feed_valid = feed_valid_q;
    assign wr_err     = wr_err_q;
    assign a_edge     = a_edge_q;
    assign b_edge     = b_edge_q;

endmodule
`default_nettype wire
